zone_climate_ctrl: RTL
======================

Name: zone_climate_ctrl

Overview:
Multi-zone HVAC controller; parametrised successor of the single-zone AC block in the Smart_Home top. Each zone runs a heat/cool state machine with hysteresis and an anti-short-cycle dwell timer. A shared power budget caps simultaneously active zones, and a round-robin arbiter grants new starts. Instantiated in Smart_Home in place of the single AC instance; heating/cooling become per-zone vectors.

Parameters:
NZONES, 4, number of climate zones
TEMP_W, 5, temperature/setpoint width (unsigned)
HYST, 2, hysteresis half-band in temperature units
DWELL, 4, minimum cycles in any state before leaving it (1..255)
MAX_ACTIVE, 2, max zones in HEAT or COOL at once (1..NZONES)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  global enable; low forces all zones off
temperature  in  NZONES*TEMP_W  zone i temperature at [i*TEMP_W +: TEMP_W]
setpoint  in  NZONES*TEMP_W  zone i setpoint, same packing
heating  out  NZONES  zone i heater on (registered)
cooling  out  NZONES  zone i cooler on (registered)
active_cnt  out  $clog2(MAX_ACTIVE+1)  zones currently in HEAT/COOL (registered)
stall  out  1  at least one zone requesting but denied this cycle (registered)

Behaviour:
- Reset: all zones IDLE; heating=0, cooling=0, active_cnt=0, stall=0; dwell counters=0; round-robin pointer=0.
- Per-zone states: IDLE, HEAT, COOL. A direct HEAT<->COOL transition is illegal; the zone must pass through IDLE.
- Thresholds are computed at TEMP_W+1 bits and clamped: lo = max(sp-HYST, 0), hi = min(sp+HYST, 2^TEMP_W-1).
- Heat request: state IDLE, dwell expired, temp < lo (strict).
- Cool request: state IDLE, dwell expired, temp > hi (strict).
- With sp=0, heat is never requested. With sp=max, cool is never requested.
- Exit conditions: HEAT to IDLE when temp >= sp and dwell expired. COOL to IDLE when temp <= sp and dwell expired.
- Dwell: the counter loads DWELL on every state entry and decrements to 0; "expired" means the counter is 0. A zone leaving reset starts expired.
- Arbitration: at each edge, at most one IDLE requester is granted.
  - The search starts at the RR pointer and wraps modulo NZONES.
  - A grant occurs only if registered active_cnt < MAX_ACTIVE.
  - After a grant, the pointer moves to granted+1 (mod NZONES). Otherwise the pointer is unchanged.
- Budget uses the registered active_cnt. A slot freed by a zone exiting at edge N is usable at edge N+1; no same-edge exit/enter reuse.
- Latency: heating/cooling reflect the state register, so an output rises at the edge where the grant is taken (one edge after the temperature is stable).
- stall is registered: it is 1 for the cycle after an edge at which any zone requested and was not granted.
- en=0: at the next edge all zones go to IDLE with dwell=0, ignoring dwell. Outputs clear, active_cnt=0, the pointer holds, and no requests are granted while en=0.
- Asynchronous rst mid-operation clears everything immediately, regardless of dwell.
- Temperature inputs are assumed synchronous to clk; no internal synchronisers.

Decomposition:
- Package smart_home_pkg:
  - zone_state_t enum (IDLE/HEAT/COOL)
  - function clamp_sub/clamp_add for threshold saturation
  - constant DWELL_W=8
- Sub-module climate_zone_fsm, one per zone (generate loop). Takes temp, sp, grant, en; produces heat_req, cool_req, state, active.
- Round-robin arbiter and active counter live in zone_climate_ctrl.

Test Plan:
Defaults for all scenarios: NZONES=4, TEMP_W=5, HYST=2, DWELL=4, MAX_ACTIVE=2, en=1.
1. Zone0 sp=20, temp=18 -> no heat (18 not < 18). temp=17 -> heating[0]=1 at next edge, active_cnt=1.
2. Zone0 heating, temp jumps to 21 one cycle after entry -> heating[0] holds 4 cycles, then drops. Then set temp=23 -> cooling[0] stays 0 until 4 IDLE cycles elapse, then rises.
3. All zones sp=20, temp=10 simultaneously -> zone0 granted edge1, zone1 edge2. Zones 2,3 wait with stall=1 and active_cnt=2. Zone0 exits at edge N -> zone2 granted at edge N+1, then zone1 exit lets zone3 in.
4. Zones 0 and 1 in HEAT/COOL, en pulled low for 1 cycle -> all outputs 0 next edge, ignoring dwell. en back to 1 with temps still out of band -> restart from RR pointer at the next edge.
5. Zone2 sp=0, temp=0 and zone3 sp=31, temp=31 -> no heat/cool ever (saturation). Zone3 temp=31, sp=28 -> cool (31 > 30).
6. Assert rst mid-HEAT, dwell=2 -> heating, cooling, active_cnt, stall cleared immediately. After release, a zone below lo re-heats at the first edge.

Source files
------------

// File: rtl/smart_home_pkg.sv
// Shared types and helpers for the Smart_Home climate blocks.
// Saturating threshold arithmetic lives here so every zone clamps identically.
package smart_home_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAT = 2'd1,
      COOL = 2'd2
   } zone_state_t;

   localparam int DWELL_W = 8;

   function automatic int clamp_sub(input int a, input int b);
      return (a > b) ? (a - b) : 0;
   endfunction

   function automatic int clamp_add(input int a, input int b, input int mx);
      return ((a + b) > mx) ? mx : (a + b);
   endfunction

endpackage

// File: rtl/climate_zone_fsm.sv
// One climate zone: IDLE/HEAT/COOL with hysteresis and dwell timer.
// Requests are raised here; the top decides which one is granted.
module climate_zone_fsm
   import smart_home_pkg::*;
#(
   parameter int TEMP_W = 5,
   parameter int HYST   = 2,
   parameter int DWELL  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic [TEMP_W-1:0] i_temp,
   input  logic [TEMP_W-1:0] i_sp,
   input  logic              i_grant,
   output logic              o_heat_req,
   output logic              o_cool_req,
   output zone_state_t       o_state,
   output logic              o_active_nxt
);

   localparam int TMAX = (1 << TEMP_W) - 1;

   zone_state_t        r_state;
   zone_state_t        w_state_nxt;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] w_dwell_nxt;
   logic [TEMP_W:0]    w_lo;
   logic [TEMP_W:0]    w_hi;
   logic [TEMP_W:0]    w_temp;
   logic               w_expired;

   // Thresholds at TEMP_W+1 bits so sp=0 / sp=max never wrap.
   assign w_lo   = (TEMP_W+1)'(clamp_sub(int'(i_sp), HYST));
   assign w_hi   = (TEMP_W+1)'(clamp_add(int'(i_sp), HYST, TMAX));
   assign w_temp = {1'b0, i_temp};
   assign w_expired = (r_dwell == '0);

   assign o_heat_req = i_en && (r_state == IDLE) && w_expired && (w_temp < w_lo);
   assign o_cool_req = i_en && (r_state == IDLE) && w_expired && (w_temp > w_hi);
   assign o_state      = r_state;
   assign o_active_nxt = (w_state_nxt != IDLE);

   always_comb begin
      w_state_nxt = r_state;
      w_dwell_nxt = w_expired ? '0 : (r_dwell - DWELL_W'(1));
      if (!i_en) begin
         w_state_nxt = IDLE;
         w_dwell_nxt = '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_grant && o_heat_req) begin
                  w_state_nxt = HEAT;
                  w_dwell_nxt = DWELL_W'(DWELL);
               end else if (i_grant && o_cool_req) begin
                  w_state_nxt = COOL;
                  w_dwell_nxt = DWELL_W'(DWELL);
               end
            end
            HEAT: begin
               if (w_expired && (i_temp >= i_sp)) begin
                  w_state_nxt = IDLE;
                  w_dwell_nxt = DWELL_W'(DWELL);
               end
            end
            COOL: begin
               if (w_expired && (i_temp <= i_sp)) begin
                  w_state_nxt = IDLE;
                  w_dwell_nxt = DWELL_W'(DWELL);
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_dwell_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_dwell <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dwell <= w_dwell_nxt;
      end
   end

endmodule

// File: rtl/zone_climate_ctrl.sv
// Multi-zone HVAC controller: per-zone FSMs sharing a power budget.
// A round-robin arbiter grants at most one new start per edge.
module zone_climate_ctrl
   import smart_home_pkg::*;
#(
   parameter  int NZONES     = 4,
   parameter  int TEMP_W     = 5,
   parameter  int HYST       = 2,
   parameter  int DWELL      = 4,
   parameter  int MAX_ACTIVE = 2,
   localparam int CNT_W      = $clog2(MAX_ACTIVE + 1),
   localparam int PTR_W      = (NZONES > 1) ? $clog2(NZONES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NZONES*TEMP_W-1:0] temperature,
   input  logic [NZONES*TEMP_W-1:0] setpoint,
   output logic [NZONES-1:0]        heating,
   output logic [NZONES-1:0]        cooling,
   output logic [CNT_W-1:0]         active_cnt,
   output logic                     stall
);

   zone_state_t       w_state [NZONES];
   logic [NZONES-1:0] w_heat_req;
   logic [NZONES-1:0] w_cool_req;
   logic [NZONES-1:0] w_req;
   logic [NZONES-1:0] w_grant;
   logic [NZONES-1:0] w_act_nxt;
   logic [PTR_W-1:0]  r_ptr;
   logic [PTR_W-1:0]  w_ptr_nxt;
   logic [PTR_W-1:0]  w_idx;
   logic              w_found;
   logic [CNT_W-1:0]  r_active_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_stall;

   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NZONES - 1)) ? '0 : (p + PTR_W'(1));
   endfunction

   for (genvar g = 0; g < NZONES; g++) begin : g_zone
      climate_zone_fsm #(
         .TEMP_W (TEMP_W),
         .HYST   (HYST),
         .DWELL  (DWELL)
      ) u_fsm (
         .clk          (clk),
         .rst          (rst),
         .i_en         (en),
         .i_temp       (temperature[g*TEMP_W +: TEMP_W]),
         .i_sp         (setpoint[g*TEMP_W +: TEMP_W]),
         .i_grant      (w_grant[g]),
         .o_heat_req   (w_heat_req[g]),
         .o_cool_req   (w_cool_req[g]),
         .o_state      (w_state[g]),
         .o_active_nxt (w_act_nxt[g])
      );
      assign heating[g] = (w_state[g] == HEAT);
      assign cooling[g] = (w_state[g] == COOL);
   end

   assign w_req = w_heat_req | w_cool_req;

   // Budget check uses the registered count: no same-edge slot reuse.
   always_comb begin
      w_grant   = '0;
      w_ptr_nxt = r_ptr;
      w_found   = 1'b0;
      w_idx     = r_ptr;
      if (en && (r_active_cnt < CNT_W'(MAX_ACTIVE))) begin
         for (int k = 0; k < NZONES; k++) begin
            if (!w_found && w_req[w_idx]) begin
               w_found        = 1'b1;
               w_grant[w_idx] = 1'b1;
               w_ptr_nxt      = f_inc(w_idx);
            end
            w_idx = f_inc(w_idx);
         end
      end
   end

   always_comb begin
      w_cnt_nxt = '0;
      for (int i = 0; i < NZONES; i++) begin
         w_cnt_nxt = w_cnt_nxt + CNT_W'(w_act_nxt[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr        <= '0;
         r_active_cnt <= '0;
         r_stall      <= 1'b0;
      end else begin
         r_ptr        <= w_ptr_nxt;
         r_active_cnt <= w_cnt_nxt;
         r_stall      <= |(w_req & ~w_grant);
      end
   end

   assign active_cnt = r_active_cnt;
   assign stall      = r_stall;

endmodule
